// File: rtl/operand_fetch.sv
// operand_fetch: sequences direct/indirect memory reads that produce the ALU mem_data operand
package operand_fetch_pkg;
    typedef enum logic [1:0] {
        SRC_MEM_ADDR  = 2'd0,
        SRC_IMMEDIATE = 2'd1,
        SRC_INDIRECT  = 2'd2,
        SRC_REG       = 2'd3
    } data_src_t;
endpackage

module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  data_src_t             source,
    input  logic [WIDTH-1:0]      id_operand,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      mem_data,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [WIDTH-1:0]      mem_rdata
);
    typedef enum logic [2:0] {IDLE, PTR_REQ, PTR_WAIT, DATA_REQ, DATA_WAIT, DONE} state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;

    assign mem_addr = addr_q;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (start) state_d = source == SRC_MEM_ADDR ? DATA_REQ :
                                            source == SRC_INDIRECT ? PTR_REQ : DONE;
            PTR_REQ:   if (mem_ready) state_d = PTR_WAIT;
            PTR_WAIT:  state_d = DATA_REQ;
            DATA_REQ:  if (mem_ready) state_d = DATA_WAIT;
            DATA_WAIT: state_d = DONE;
            default:   state_d = IDLE;
        endcase
    end

    // status outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
        end else begin
            state  <= state_d;
            busy   <= state_d != IDLE;
            done   <= state_d == DONE;
            mem_rd <= state_d == PTR_REQ || state_d == DATA_REQ;
            if (state == IDLE && start) addr_q <= ADDR_WIDTH'(id_operand);
            if (state == PTR_WAIT) addr_q <= ADDR_WIDTH'(mem_rdata);
            if (state == DATA_WAIT) mem_data <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks of operand_fetch against a one-cycle-latency memory model
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic       clk = 0;
    logic       rst_n, start, busy, done, mem_rd, mem_ready;
    data_src_t  source;
    logic [7:0] id_operand, mem_data, mem_addr, mem_rdata;
    logic [7:0] mem [256];
    logic [2:0] exp;
    int         total = 0, bad = 0;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .source(source), .id_operand(id_operand),
        .busy(busy), .done(done), .mem_data(mem_data), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // data only comes back the cycle after an accepted request; otherwise garbage
    always @(posedge clk) mem_rdata <= (mem_rd && mem_ready) ? mem[mem_addr] : 8'hEE;

    task automatic issue(input data_src_t s, input logic [7:0] a);
        @(posedge clk); #1;
        start = 1; source = s; id_operand = a; mem_ready = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; mem_ready = 1; source = SRC_REG; id_operand = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, mem_rd} !== 3'b000) begin
            bad++; $display("FAIL reset flags got %b want 000", {busy, done, mem_rd});
        end
        total++;
        if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset addr got %h want 00", mem_addr); end
        total++;
        if (mem_data !== 8'h00) begin bad++; $display("FAIL reset data got %h want 00", mem_data); end
        rst_n = 1;
    endtask

    task automatic test_direct();
        issue(SRC_MEM_ADDR, 8'h20);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start = 0;
            exp = {c <= 3, c == 3, c == 1};
            total++;
            if ({busy, done, mem_rd} !== exp) begin
                bad++; $display("FAIL direct c%0d busy/done/rd got %b want %b", c, {busy, done, mem_rd}, exp);
            end
            if (c == 1) begin
                total++;
                if (mem_addr !== 8'h20) begin bad++; $display("FAIL direct addr got %h want 20", mem_addr); end
            end
            if (c == 3) begin
                total++;
                if (mem_data !== 8'h5A) begin bad++; $display("FAIL direct data got %h want 5a", mem_data); end
            end
        end
    endtask

    task automatic test_indirect();
        issue(SRC_INDIRECT, 8'h10);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            start = 0;
            exp = {c <= 5, c == 5, c == 1 || c == 3};
            total++;
            if ({busy, done, mem_rd} !== exp) begin
                bad++; $display("FAIL indirect c%0d busy/done/rd got %b want %b", c, {busy, done, mem_rd}, exp);
            end
            if (c == 1 || c == 3) begin
                total++;
                if (mem_addr !== (c == 1 ? 8'h10 : 8'h33)) begin
                    bad++; $display("FAIL indirect addr c%0d got %h want %h", c, mem_addr, c == 1 ? 8'h10 : 8'h33);
                end
            end
            if (c == 5) begin
                total++;
                if (mem_data !== 8'hC4) begin bad++; $display("FAIL indirect data got %h want c4", mem_data); end
            end
        end
    endtask

    task automatic test_no_mem();
        for (int k = 0; k < 2; k++) begin
            issue(k == 0 ? SRC_IMMEDIATE : SRC_REG, 8'h20);
            for (int c = 1; c <= 2; c++) begin
                @(posedge clk); #1;
                start = 0;
                exp = {c == 1, c == 1, 1'b0};
                total++;
                if ({busy, done, mem_rd} !== exp) begin
                    bad++; $display("FAIL nomem%0d c%0d busy/done/rd got %b want %b", k, c, {busy, done, mem_rd}, exp);
                end
                total++;
                if (mem_data !== 8'hC4) begin bad++; $display("FAIL nomem%0d data c%0d got %h want c4", k, c, mem_data); end
            end
        end
    endtask

    task automatic test_stall();
        issue(SRC_INDIRECT, 8'h50);
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            start = 0;
            mem_ready = !(c inside {1, 2, 3, 6, 7});
            exp = {c <= 10, c == 10, (c >= 1 && c <= 4) || (c >= 6 && c <= 8)};
            total++;
            if ({busy, done, mem_rd} !== exp) begin
                bad++; $display("FAIL stall c%0d busy/done/rd got %b want %b", c, {busy, done, mem_rd}, exp);
            end
            if (exp[0]) begin
                total++;
                if (mem_addr !== (c <= 4 ? 8'h50 : 8'h60)) begin
                    bad++; $display("FAIL stall addr c%0d got %h want %h", c, mem_addr, c <= 4 ? 8'h50 : 8'h60);
                end
            end
            if (c == 10) begin
                total++;
                if (mem_data !== 8'h9B) begin bad++; $display("FAIL stall data got %h want 9b", mem_data); end
            end
        end
        mem_ready = 1;
    endtask

    task automatic test_start_busy();
        issue(SRC_MEM_ADDR, 8'h20);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = c == 2;
            if (c == 2) begin source = SRC_MEM_ADDR; id_operand = 8'h44; end
            exp = {c <= 3, c == 3, c == 1};
            total++;
            if ({busy, done, mem_rd} !== exp) begin
                bad++; $display("FAIL busystart c%0d busy/done/rd got %b want %b", c, {busy, done, mem_rd}, exp);
            end
            if (c == 3) begin
                total++;
                if (mem_data !== 8'h5A) begin bad++; $display("FAIL busystart data got %h want 5a", mem_data); end
            end
        end
        start = 0;
    endtask

    task automatic test_back_to_back();
        issue(SRC_IMMEDIATE, 8'h00);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            start = c <= 2;
            if (c == 1) begin source = SRC_INDIRECT; id_operand = 8'h10; end
            if (c == 2) begin source = SRC_MEM_ADDR; id_operand = 8'h20; end
            exp = {c == 1 || (c >= 3 && c <= 5), c == 1 || c == 5, c == 3};
            total++;
            if ({busy, done, mem_rd} !== exp) begin
                bad++; $display("FAIL b2b c%0d busy/done/rd got %b want %b", c, {busy, done, mem_rd}, exp);
            end
            if (c == 3) begin
                total++;
                if (mem_addr !== 8'h20) begin bad++; $display("FAIL b2b addr got %h want 20", mem_addr); end
            end
            if (c == 5) begin
                total++;
                if (mem_data !== 8'h5A) begin bad++; $display("FAIL b2b data got %h want 5a", mem_data); end
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(SRC_INDIRECT, 8'h10);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start = 0;
            rst_n = c != 2;
            if (c >= 3) begin
                total++;
                if ({busy, done, mem_rd} !== 3'b000) begin
                    bad++; $display("FAIL rstmid c%0d busy/done/rd got %b want 000", c, {busy, done, mem_rd});
                end
                total++;
                if (mem_data !== 8'h00) begin bad++; $display("FAIL rstmid data c%0d got %h want 00", c, mem_data); end
            end
        end
        test_direct();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h20] = 8'h5A;
        mem[8'h10] = 8'h33;
        mem[8'h33] = 8'hC4;
        mem[8'h50] = 8'h60;
        mem[8'h60] = 8'h9B;
        mem[8'h44] = 8'h77;
        test_reset();
        test_direct();
        test_indirect();
        test_no_mem();
        test_stall();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
